// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths, control-bit indices and stage state encoding for the MIPS pipeline
package mips_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Decoded control bundle layout carried from ID through WB
    localparam int CTRL_W       = 12;
    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;
    localparam int MEMWRITE_BIT = 2;
    localparam int MEMREAD_BIT  = 3;
    localparam int ALUSRC_BIT   = 4;
    localparam int REGDST_BIT   = 5;
    localparam int BRANCH_BIT   = 6;
    localparam int JUMP_BIT     = 7;
    localparam int ALUOP_LSB    = 8;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } stage_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection between ID and EX
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  haz
);

    // A load in EX whose destination is read by ID cannot be forwarded in time;
    // register 0 is hardwired and never creates a dependency.
    assign haz = id_valid & ex_valid & ex_memread & (ex_rt != REG_ZERO) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall/bubble; optional WB_BYPASS_EN write-back bypass
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int CTRL_W       = mips_pipe_pkg::CTRL_W,
    parameter int MEMREAD_BIT  = mips_pipe_pkg::MEMREAD_BIT,
    parameter int REGWRITE_BIT = mips_pipe_pkg::REGWRITE_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rdata1,
    input  logic [DATA_W-1:0]     id_rdata2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [31:0]           stall_cnt
);

    stage_state_t      state;
    stage_state_t      state_nxt;
    logic              haz;
    logic              capture;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              unused_ok;

    hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl[MEMREAD_BIT]),
        .ex_rt      (ex_rt),
        .haz        (haz)
    );

    // A redirect kills the ID instruction anyway, so it never needs to be held.
    assign stall = haz & ~flush;

`ifdef WB_BYPASS_EN
    // Regfile reads do not see a same-cycle write, so pick up the WB value directly.
    assign op_a = (wb_en && wb_addr != REG_ZERO && wb_addr == id_rs) ? wb_data : id_rdata1;
    assign op_b = (wb_en && wb_addr != REG_ZERO && wb_addr == id_rt) ? wb_data : id_rdata2;
    assign unused_ok = id_ctrl[REGWRITE_BIT];
`else
    assign op_a = id_rdata1;
    assign op_b = id_rdata2;
    assign unused_ok = ^{wb_en, wb_addr, wb_data, id_ctrl[REGWRITE_BIT]};
`endif

    // Next-state and capture decision: flush beats stall beats normal capture.
    always_comb begin
        state_nxt = RUN;
        capture   = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = RUN;
                end else if (stall) begin
                    state_nxt = BUBBLE;
                end else begin
                    capture = id_valid;
                end
            end
            BUBBLE: begin
                state_nxt = RUN;
                capture   = id_valid & ~flush;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Pipeline register, state register and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (capture) begin
                ex_valid <= 1'b1;
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_rd    <= id_rd;
                ex_a     <= op_a;
                ex_b     <= op_b;
                ex_imm   <= id_imm;
                ex_ctrl  <= id_ctrl;
            end else begin
                ex_valid <= 1'b0;
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_rd    <= '0;
                ex_a     <= '0;
                ex_b     <= '0;
                ex_imm   <= '0;
                ex_ctrl  <= '0;
            end
        end
    end

    // EX never holds a load while in BUBBLE, so a stall here means broken hazard logic.
    always_ff @(posedge clk) begin
        if (!rst && state == BUBBLE) begin
            assert (!stall);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam logic [11:0] C_LW  = 12'h019;
    localparam logic [11:0] C_ADD = 12'h021;

    typedef struct packed {
        logic        valid;
        logic [11:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [11:0] id_ctrl;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [11:0] ex_ctrl;
    logic [31:0] stall_cnt;

    exp_t q[$];
    exp_t m = '0;
    bit   m_known = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    id_ex_stage dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_rdata1 (id_rdata1),
        .id_rdata2 (id_rdata2),
        .id_imm    (id_imm),
        .id_ctrl   (id_ctrl),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .ex_rs     (ex_rs),
        .ex_rt     (ex_rt),
        .ex_rd     (ex_rd),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_imm    (ex_imm),
        .ex_ctrl   (ex_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [11:0] ctrl);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = a;
        id_rdata2 = b;
        id_imm    = imm;
        id_ctrl   = ctrl;
    endtask

    // One clock: predict stall and the next EX contents, push, clock, pop and compare.
    task automatic step();
        exp_t n;
        exp_t e;
        logic haz;
        logic st;
        #2;
        haz = id_valid && m.valid && m.ctrl[3] && (m.rt != 5'd0) &&
              ((m.rt == id_rs) || (m.rt == id_rt));
        st = haz && !flush;
        if (!rst && m_known) check("stall", 32'(stall), 32'(st));
        n = '0;
        if (rst) begin
            n = '0;
        end else if (flush || st || !id_valid) begin
            n.cnt = m.cnt + 32'(st);
        end else begin
            n.valid = 1'b1;
            n.ctrl  = id_ctrl;
            n.rs    = id_rs;
            n.rt    = id_rt;
            n.rd    = id_rd;
            n.imm   = id_imm;
            n.cnt   = m.cnt;
`ifdef WB_BYPASS_EN
            n.a = (wb_en && wb_addr != 5'd0 && wb_addr == id_rs) ? wb_data : id_rdata1;
            n.b = (wb_en && wb_addr != 5'd0 && wb_addr == id_rt) ? wb_data : id_rdata2;
`else
            n.a = id_rdata1;
            n.b = id_rdata2;
`endif
        end
        q.push_back(n);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check("ex_valid", 32'(ex_valid), 32'(e.valid));
            check("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
            check("ex_rs_rt_rd", 32'({ex_rs, ex_rt, ex_rd}), 32'({e.rs, e.rt, e.rd}));
            check("ex_a", ex_a, e.a);
            check("ex_b", ex_b, e.b);
            check("ex_imm", ex_imm, e.imm);
            check("stall_cnt", stall_cnt, e.cnt);
            m = e;
            if (rst) m_known = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wb_en = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 12'd0);
        step();
        step();
        check("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Plain ADD, no hazard
        set_id(1'b1, 5'd2, 5'd3, 5'd1, 32'd5, 32'd7, 32'd0, C_ADD);
        step();
        check("add_ex_a", ex_a, 32'd5);
        check("add_ex_b", ex_b, 32'd7);

        // Load-use on rs: one stall cycle, bubble, then dependent enters EX
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 32'd100, 32'd200, 32'd8, C_LW);
        step();
        set_id(1'b1, 5'd4, 5'd5, 5'd6, 32'd11, 32'd22, 32'd0, C_ADD);
        step();
        check("stall_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        check("stall_cnt_first", stall_cnt, 32'd1);
        step();
        check("after_stall_valid", 32'(ex_valid), 32'd1);
        check("after_stall_rs", 32'(ex_rs), 32'd4);

        // Load into r0 never stalls
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'd1, 32'd2, 32'd4, C_LW);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, C_ADD);
        step();

        // Load-use coinciding with flush: flush wins, counter untouched
        set_id(1'b1, 5'd1, 5'd6, 5'd0, 32'd1, 32'd2, 32'd4, C_LW);
        step();
        set_id(1'b1, 5'd1, 5'd6, 5'd2, 32'd9, 32'd9, 32'd0, C_ADD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_cnt_held", stall_cnt, 32'd1);

        // Load-use on rt
        set_id(1'b1, 5'd1, 5'd7, 5'd0, 32'd1, 32'd2, 32'd4, C_LW);
        step();
        set_id(1'b1, 5'd3, 5'd7, 5'd2, 32'd3, 32'd4, 32'd0, C_ADD);
        step();
        step();

        // WB bypass on both operands
        wb_en = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h1234;
        set_id(1'b1, 5'd9, 5'd9, 5'd1, 32'd0, 32'd0, 32'd0, C_ADD);
        step();
`ifdef WB_BYPASS_EN
        check("bypass_ex_a", ex_a, 32'h1234);
`else
        check("no_bypass_ex_a", ex_a, 32'd0);
`endif

        // Write to r0 is never bypassed
        wb_addr = 5'd0;
        wb_data = 32'h5555;
        set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'd3, 32'd0, 32'd0, C_ADD);
        step();
        check("r0_no_bypass", ex_a, 32'd3);
        wb_en = 1'b0;

        // No instruction in ID
        id_valid = 1'b0;
        step();

        // Reset while in BUBBLE
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2, 32'd4, C_LW);
        step();
        set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, C_ADD);
        step();
        rst = 1'b1;
        step();
        check("midstall_reset_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        step();

        // Randomised traffic over a small register set to provoke hazards
        for (int i = 0; i < 40; i++) begin
            id_valid  = ($urandom_range(0, 7) != 0);
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            id_rd     = 5'($urandom_range(0, 31));
            id_rdata1 = $urandom;
            id_rdata2 = $urandom;
            id_imm    = $urandom;
            id_ctrl   = 12'($urandom_range(0, 4095));
            flush     = ($urandom_range(0, 7) == 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the pipelined MIPS core. It sits directly downstream of the register file and registers the decode-stage operands (regfile read data, register addresses, immediate, control bundle) for the execute stage. It also detects load-use hazards, generating a one-cycle stall and a bubble. Flushes from taken branches insert bubbles.

Parameters:
CTRL_W, 12, width of the decoded control bundle passed to EX/MEM/WB.
MEMREAD_BIT, 3, index of the mem-read (load) bit inside the control bundle.
REGWRITE_BIT, 0, index of the reg-write bit inside the control bundle.

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  5  source register 1 address (same value driven to regfile radd1)
id_rt  in  5  source register 2 / load destination address
id_rd  in  5  R-type destination address
id_rdata1  in  32  regfile out1
id_rdata2  in  32  regfile out2
id_imm  in  32  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control bundle
flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
wb_en  in  1  WB-stage write enable (same signal as regfile en_write)
wb_addr  in  5  WB-stage write address (regfile wadd)
wb_data  in  32  WB-stage write data (regfile data)
stall  out  1  hold PC and IF/ID register this cycle
ex_valid  out  1  EX holds a real instruction
ex_rs, ex_rt, ex_rd  out  5 each  registered addresses
ex_a, ex_b  out  32 each  registered operands
ex_imm  out  32  registered immediate
ex_ctrl  out  CTRL_W  registered control; all-zero for a bubble
stall_cnt  out  32  count of stall cycles since reset

Behaviour:
- Reset (rst=1 at posedge): ex_valid=0, ex_ctrl=0, all ex_* data/address outputs 0, stall_cnt=0, FSM=RUN. stall is combinational but forced 0 while ex_valid=0, so it reads 0 after reset.
- Latency: one cycle. The ID values present at posedge N appear on ex_* after posedge N.
- Hazard (combinational): haz = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
- stall = haz & ~flush.
- FSM states:
  - RUN:
    - Capture ID normally.
    - On stall: load a bubble (ex_valid=0, ex_ctrl=0, addresses/data 0), stall_cnt+=1, go to BUBBLE.
  - BUBBLE:
    - EX holds no load, so haz=0 by construction.
    - Capture the now-unstalled ID instruction and return to RUN.
    - If stall is ever observed in BUBBLE, that is a design error; assert in simulation.
- Flush has priority over stall and capture. flush=1 loads a bubble, leaves stall_cnt unchanged, and sets FSM=RUN.
- id_valid=0 with no stall and no flush: capture a bubble (ex_valid=0, ex_ctrl=0).
- Register 0 never triggers a hazard or a bypass.
- stall_cnt wraps from 0xFFFFFFFF to 0.
- Reset mid-stall: the bubble is discarded, FSM=RUN, and outputs take their reset values.

Optional Feature:
WB_BYPASS_EN.
- Defined: the register file only updates on posedge and its reads do not re-evaluate on a write. So when wb_en=1, wb_addr!=0 and wb_addr==id_rs, ex_a captures wb_data instead of id_rdata1. The same rule applies to id_rt, ex_b and id_rdata2. Both operands may be bypassed at once.
- Undefined: ex_a/ex_b always capture id_rdata1/id_rdata2. Software must separate a WB write from a dependent decode by at least one instruction.

Decomposition:
- Package mips_pipe_pkg holds:
  - DATA_W=32, REG_ADDR_W=5, REG_ZERO=5'd0
  - CTRL_W and the control-bit index constants (REGWRITE_BIT, MEMREAD_BIT, MEMWRITE_BIT, ALUSRC_BIT, ...)
  - FSM state encoding: RUN=1'b0, BUBBLE=1'b1
- One sub-module, hazard_detect: purely combinational. It takes id_valid, id_rs, id_rt, ex_valid, ex_memread and ex_rt, and produces haz.

Test Plan:
- Reset with rst=1 for 2 cycles -> ex_valid=0, ex_ctrl=0, stall=0, stall_cnt=0.
- ADD with id_rs=2, id_rt=3, rdata1=5, rdata2=7, no hazard -> next cycle ex_a=5, ex_b=7, ex_rs=2, ex_valid=1; stall stays 0.
- LW in EX with ex_rt=4, then ID reads id_rs=4 -> stall=1 for exactly one cycle, EX gets a bubble (ex_ctrl=0), stall_cnt=1; the following cycle the dependent instruction enters EX with ex_valid=1.
- LW in EX with ex_rt=0, then ID reads id_rs=0 -> no stall.
- Load-use hazard with flush=1 in the same cycle -> stall=0, bubble loaded, stall_cnt unchanged.
- With WB_BYPASS_EN: wb_en=1, wb_addr=9, wb_data=0x1234, id_rs=9, id_rdata1=0 -> ex_a=0x1234.
- Without WB_BYPASS_EN, same stimulus -> ex_a=0.
- With WB_BYPASS_EN and wb_addr=0 -> no bypass.
